// File: rtl/crd_pkg.sv
// Shared token definitions for the sparse coordinate-drop unit.
// Tokens are 17 bits wide: bit 16 clear marks a data coordinate, bit 16 set
// marks a control token (stop with a level in [7:0], or the done token).
package crd_pkg;

   localparam int unsigned TOK_W = 17;

   typedef logic [TOK_W-1:0] token_t;

   localparam token_t DONE      = 17'h10100;
   localparam token_t STOP_BASE = 17'h10000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_DONE_WAIT
   } state_e;

   function automatic logic is_data(input token_t t);
      return !t[16];
   endfunction

   function automatic logic is_done(input token_t t);
      return t == DONE;
   endfunction

   function automatic logic is_stop(input token_t t);
      return t[16] && (t[15:8] == 8'h00);
   endfunction

   function automatic logic [7:0] stop_level(input token_t t);
      return t[7:0];
   endfunction

   function automatic token_t make_stop(input logic [7:0] lvl);
      return STOP_BASE | token_t'(lvl);
   endfunction

endpackage

// File: rtl/reg_fifo.sv
// Two-entry registered FIFO driving one output stream. The producer only
// pushes when full_o is low and the consumer only pops when valid_o is high.
module reg_fifo
   import crd_pkg::*;
(
   input  logic   clk,
   input  logic   flush_i,
   input  logic   push_i,
   input  token_t data_i,
   input  logic   pop_i,
   output logic   full_o,
   output logic   valid_o,
   output token_t data_o
);

   token_t     mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;

   // Storage, pointers and occupancy update.
   always_ff @(posedge clk) begin
      if (flush_i) begin
         // NOTE: the storage is cleared too, because the data output must read
         // zero after a flush, not just be marked invalid.
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign full_o  = (count_q == 2'd2);
   assign valid_o = (count_q != 2'd0);
   assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/crd_drop.sv
// Coordinate-drop unit: removes outer coordinates whose inner fiber is empty
// and merges the inner stop tokens those empty fibers leave behind. The
// inner stop that closes a fiber is held back in a one-entry pending
// register, so a run of empty fibers after it can still raise its level.
module crd_drop
   import crd_pkg::*;
(
   input  logic        clk,
   input  logic        flush,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic        tile_en,
   input  logic        cmrg_enable,
   input  logic [15:0] cmrg_stop_lvl,
   input  logic        cmrg_mode,
   input  logic [16:0] cmrg_coord_in_0,
   input  logic        cmrg_coord_in_0_valid,
   output logic        cmrg_coord_in_0_ready,
   input  logic [16:0] cmrg_coord_in_1,
   input  logic        cmrg_coord_in_1_valid,
   output logic        cmrg_coord_in_1_ready,
   output logic [16:0] cmrg_coord_out_0,
   output logic        cmrg_coord_out_0_valid,
   input  logic        cmrg_coord_out_0_ready,
   output logic [16:0] cmrg_coord_out_1,
   output logic        cmrg_coord_out_1_valid,
   input  logic        cmrg_coord_out_1_ready
);

   // Ports kept for interface compatibility; they have no function here.
   logic unused_ok;
   assign unused_ok = ^{rst_n, cmrg_enable, cmrg_stop_lvl};

   state_e     state_q;
   token_t     held_q;
   logic       nonempty_q;
   logic       pend_v_q;
   logic [7:0] pend_lvl_q;

   logic   active;
   logic   rdy_0, rdy_1;
   logic   push_0, push_1;
   token_t din_0, din_1;
   logic   pend_clr;
   logic   fire_0, fire_1;
   logic   full_0, full_1;
   logic   fvalid_0, fvalid_1;
   token_t fdata_0, fdata_1;
   logic   pop_0, pop_1;
   token_t tok_0, tok_1;
   logic [7:0] lvl_1;

   assign active = clk_en && tile_en && !flush;
   assign tok_0  = cmrg_coord_in_0;
   assign tok_1  = cmrg_coord_in_1;
   assign lvl_1  = stop_level(tok_1);
   assign fire_0 = rdy_0 && cmrg_coord_in_0_valid;
   assign fire_1 = rdy_1 && cmrg_coord_in_1_valid;

   // Input acceptance and FIFO push decode for the current state.
   always_comb begin
      // NOTE: every output of this block gets a default first so that no
      // path leaves a value unassigned and infers a latch.
      rdy_0    = 1'b0;
      rdy_1    = 1'b0;
      push_0   = 1'b0;
      push_1   = 1'b0;
      din_0    = '0;
      din_1    = '0;
      pend_clr = 1'b0;
      if (active) begin
         if (cmrg_mode) begin
            rdy_0  = !full_0;
            rdy_1  = !full_1;
            push_0 = rdy_0 && cmrg_coord_in_0_valid;
            push_1 = rdy_1 && cmrg_coord_in_1_valid;
            din_0  = tok_0;
            din_1  = tok_1;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  rdy_0 = !full_0;
                  if (rdy_0 && cmrg_coord_in_0_valid && !is_data(tok_0) && !is_done(tok_0)) begin
                     push_0 = 1'b1;
                     din_0  = tok_0;
                  end
               end
               ST_HOLD: begin
                  if (pend_v_q) begin
                     // A stop may still merge into the pending stop; data
                     // waits while the pending stop goes out ahead of it.
                     rdy_1 = !is_data(tok_1);
                     if (cmrg_coord_in_1_valid && is_data(tok_1) && !full_1) begin
                        push_1   = 1'b1;
                        din_1    = make_stop(pend_lvl_q);
                        pend_clr = 1'b1;
                     end
                  end else begin
                     rdy_1 = !full_1 && (nonempty_q || !full_0);
                     if (rdy_1 && cmrg_coord_in_1_valid && is_data(tok_1)) begin
                        push_1 = 1'b1;
                        din_1  = tok_1;
                        if (!nonempty_q) begin
                           push_0 = 1'b1;
                           din_0  = held_q;
                        end
                     end
                  end
               end
               ST_DONE_WAIT: begin
                  if (pend_v_q) begin
                     if (!full_1) begin
                        push_1   = 1'b1;
                        din_1    = make_stop(pend_lvl_q);
                        pend_clr = 1'b1;
                     end
                  end else begin
                     rdy_1 = !full_0 && !full_1;
                     if (rdy_1 && cmrg_coord_in_1_valid && is_done(tok_1)) begin
                        push_0 = 1'b1;
                        push_1 = 1'b1;
                        din_0  = DONE;
                        din_1  = DONE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Drop-mode FSM: held coordinate, fiber occupancy and pending stop.
   always_ff @(posedge clk) begin
      if (flush) begin
         state_q    <= ST_IDLE;
         held_q     <= '0;
         nonempty_q <= 1'b0;
         pend_v_q   <= 1'b0;
         pend_lvl_q <= '0;
      end else if (active && !cmrg_mode) begin
         // NOTE: state registers use non-blocking assignments so every
         // branch sees the values from before this clock edge.
         if (pend_clr) begin
            pend_v_q <= 1'b0;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (fire_0) begin
                  if (is_data(tok_0)) begin
                     held_q     <= tok_0;
                     nonempty_q <= 1'b0;
                     state_q    <= ST_HOLD;
                  end else if (is_done(tok_0)) begin
                     state_q <= ST_DONE_WAIT;
                  end
               end
            end
            ST_HOLD: begin
               if (fire_1) begin
                  if (is_data(tok_1)) begin
                     nonempty_q <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                     if (nonempty_q) begin
                        pend_v_q   <= 1'b1;
                        pend_lvl_q <= lvl_1;
                     end else if (pend_v_q) begin
                        if (lvl_1 > pend_lvl_q) begin
                           pend_lvl_q <= lvl_1;
                        end
                     end else if (lvl_1 != 8'd0) begin
                        pend_v_q   <= 1'b1;
                        pend_lvl_q <= lvl_1;
                     end
                  end
               end
            end
            ST_DONE_WAIT: begin
               if (fire_1 && is_done(tok_1)) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign pop_0 = fvalid_0 && cmrg_coord_out_0_ready && clk_en && tile_en;
   assign pop_1 = fvalid_1 && cmrg_coord_out_1_ready && clk_en && tile_en;

   reg_fifo u_fifo_0 (
      .clk     (clk),
      .flush_i (flush),
      .push_i  (push_0),
      .data_i  (din_0),
      .pop_i   (pop_0),
      .full_o  (full_0),
      .valid_o (fvalid_0),
      .data_o  (fdata_0)
   );

   reg_fifo u_fifo_1 (
      .clk     (clk),
      .flush_i (flush),
      .push_i  (push_1),
      .data_i  (din_1),
      .pop_i   (pop_1),
      .full_o  (full_1),
      .valid_o (fvalid_1),
      .data_o  (fdata_1)
   );

   assign cmrg_coord_in_0_ready  = rdy_0;
   assign cmrg_coord_in_1_ready  = rdy_1;
   assign cmrg_coord_out_0       = fdata_0;
   assign cmrg_coord_out_1       = fdata_1;
   assign cmrg_coord_out_0_valid = fvalid_0 && tile_en;
   assign cmrg_coord_out_1_valid = fvalid_1 && tile_en;

endmodule

// File: tb/tb_crd_drop.sv
// Self-checking bench for crd_drop: directed streams, throttled replays,
// flush, bypass, enable gating and randomized streams against a
// fiber-level reference model.
module tb_crd_drop;
   import crd_pkg::*;

   logic        clk = 1'b0;
   logic        flush, rst_n, clk_en, tile_en, cmrg_enable, cmrg_mode;
   logic [15:0] cmrg_stop_lvl;
   logic [16:0] cmrg_coord_in_0, cmrg_coord_in_1;
   logic        cmrg_coord_in_0_valid, cmrg_coord_in_0_ready;
   logic        cmrg_coord_in_1_valid, cmrg_coord_in_1_ready;
   logic [16:0] cmrg_coord_out_0, cmrg_coord_out_1;
   logic        cmrg_coord_out_0_valid, cmrg_coord_out_0_ready;
   logic        cmrg_coord_out_1_valid, cmrg_coord_out_1_ready;

   always #5 clk = ~clk;

   crd_drop dut (
      .clk                    (clk),
      .flush                  (flush),
      .rst_n                  (rst_n),
      .clk_en                 (clk_en),
      .tile_en                (tile_en),
      .cmrg_enable            (cmrg_enable),
      .cmrg_stop_lvl          (cmrg_stop_lvl),
      .cmrg_mode              (cmrg_mode),
      .cmrg_coord_in_0        (cmrg_coord_in_0),
      .cmrg_coord_in_0_valid  (cmrg_coord_in_0_valid),
      .cmrg_coord_in_0_ready  (cmrg_coord_in_0_ready),
      .cmrg_coord_in_1        (cmrg_coord_in_1),
      .cmrg_coord_in_1_valid  (cmrg_coord_in_1_valid),
      .cmrg_coord_in_1_ready  (cmrg_coord_in_1_ready),
      .cmrg_coord_out_0       (cmrg_coord_out_0),
      .cmrg_coord_out_0_valid (cmrg_coord_out_0_valid),
      .cmrg_coord_out_0_ready (cmrg_coord_out_0_ready),
      .cmrg_coord_out_1       (cmrg_coord_out_1),
      .cmrg_coord_out_1_valid (cmrg_coord_out_1_valid),
      .cmrg_coord_out_1_ready (cmrg_coord_out_1_ready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   token_t src0[$], src1[$], exp0[$], exp1[$], got0[$], got1[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Fiber-level reference: each outer coordinate owns the inner tokens up to
   // the next inner stop; a fiber with data keeps its coordinate, the closing
   // stop is deferred and merged (max level) across following empty fibers.
   task automatic model();
      int j    = 0;
      int pend = -1;
      exp0.delete();
      exp1.delete();
      foreach (src0[i]) begin
         token_t t;
         t = src0[i];
         if (!t[16]) begin
            token_t fib[$];
            int     k;
            while (j < src1.size() && !src1[j][16]) begin
               fib.push_back(src1[j]);
               j++;
            end
            k = (j < src1.size()) ? int'(src1[j][7:0]) : 0;
            j++;
            if (fib.size() > 0) begin
               exp0.push_back(t);
               if (pend >= 0) exp1.push_back(STOP_BASE | token_t'(pend));
               foreach (fib[m]) exp1.push_back(fib[m]);
               pend = k;
            end else if (pend >= 0) begin
               pend = (k > pend) ? k : pend;
            end else if (k > 0) begin
               pend = k;
            end
         end else if (t == DONE) begin
            if (pend >= 0) exp1.push_back(STOP_BASE | token_t'(pend));
            pend = -1;
            exp0.push_back(DONE);
            exp1.push_back(DONE);
         end else begin
            exp0.push_back(t);
         end
      end
   endtask

   task automatic idle_inputs();
      cmrg_coord_in_0        = '0;
      cmrg_coord_in_1        = '0;
      cmrg_coord_in_0_valid  = 1'b0;
      cmrg_coord_in_1_valid  = 1'b0;
      cmrg_coord_out_0_ready = 1'b0;
      cmrg_coord_out_1_ready = 1'b0;
   endtask

   // Streams src0/src1 into the DUT and collects both outputs into got0/got1.
   task automatic run_stream(input string tag, input bit thr, input int max_cyc, input bit do_check);
      int     i0 = 0, i1 = 0, cyc = 0;
      bit     v0 = 0, v1 = 0, f0, f1, o0, o1, done = 0;
      token_t d0, d1;
      got0.delete();
      got1.delete();
      while (!done && cyc < max_cyc) begin
         @(negedge clk);
         if (!v0 && i0 < src0.size()) v0 = !thr || ($urandom_range(0, 3) != 0);
         if (!v1 && i1 < src1.size()) v1 = !thr || ($urandom_range(0, 3) != 0);
         cmrg_coord_in_0        = v0 ? src0[i0] : '0;
         cmrg_coord_in_1        = v1 ? src1[i1] : '0;
         cmrg_coord_in_0_valid  = v0;
         cmrg_coord_in_1_valid  = v1;
         cmrg_coord_out_0_ready = !thr || ($urandom_range(0, 2) != 0);
         cmrg_coord_out_1_ready = !thr || ($urandom_range(0, 2) != 0);
         #1;
         f0 = v0 && cmrg_coord_in_0_ready;
         f1 = v1 && cmrg_coord_in_1_ready;
         o0 = cmrg_coord_out_0_valid && cmrg_coord_out_0_ready;
         o1 = cmrg_coord_out_1_valid && cmrg_coord_out_1_ready;
         d0 = cmrg_coord_out_0;
         d1 = cmrg_coord_out_1;
         @(posedge clk);
         if (f0) begin i0++; v0 = 0; end
         if (f1) begin i1++; v1 = 0; end
         if (o0) got0.push_back(d0);
         if (o1) got1.push_back(d1);
         cyc++;
         done = (i0 == src0.size()) && (i1 == src1.size()) &&
                (got0.size() >= exp0.size()) && (got1.size() >= exp1.size());
      end
      // Drain a few cycles so late or duplicated tokens are also collected.
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         cmrg_coord_in_0_valid  = 1'b0;
         cmrg_coord_in_1_valid  = 1'b0;
         cmrg_coord_out_0_ready = 1'b1;
         cmrg_coord_out_1_ready = 1'b1;
         #1;
         o0 = cmrg_coord_out_0_valid;
         o1 = cmrg_coord_out_1_valid;
         d0 = cmrg_coord_out_0;
         d1 = cmrg_coord_out_1;
         @(posedge clk);
         if (o0) got0.push_back(d0);
         if (o1) got1.push_back(d1);
      end
      @(negedge clk);
      idle_inputs();
      if (do_check) begin
         check({tag, "_completed"}, 32'(done), 32'd1);
         check({tag, "_len0"}, got0.size(), exp0.size());
         check({tag, "_len1"}, got1.size(), exp1.size());
         foreach (exp0[k])
            check($sformatf("%s_out0[%0d]", tag, k), (k < got0.size()) ? 32'(got0[k]) : 32'hDEAD_BEEF, 32'(exp0[k]));
         foreach (exp1[k])
            check($sformatf("%s_out1[%0d]", tag, k), (k < got1.size()) ? 32'(got1[k]) : 32'hDEAD_BEEF, 32'(exp1[k]));
      end
   endtask

   task automatic load_case1();
      src0 = '{17'd5, 17'd7, 17'h10000, 17'h10100};
      src1 = '{17'd1, 17'd2, 17'h10000, 17'h10001, 17'h10100};
      exp0 = '{17'd5, 17'h10000, 17'h10100};
      exp1 = '{17'd1, 17'd2, 17'h10001, 17'h10100};
   endtask

   task automatic gen_random();
      int nseg;
      src0.delete();
      src1.delete();
      nseg = $urandom_range(1, 3);
      for (int s = 0; s < nseg; s++) begin
         int ncrd;
         ncrd = $urandom_range(0, 3);
         for (int c = 0; c < ncrd; c++) begin
            int flen;
            src0.push_back({1'b0, 16'($urandom)});
            flen = $urandom_range(0, 3);
            for (int f = 0; f < flen; f++) src1.push_back({1'b0, 16'($urandom)});
            src1.push_back(STOP_BASE | token_t'($urandom_range(0, 2)));
         end
         src0.push_back(STOP_BASE);
      end
      src0.push_back(DONE);
      src1.push_back(DONE);
   endtask

   initial begin
      rst_n         = 1'b1;
      clk_en        = 1'b1;
      tile_en       = 1'b1;
      cmrg_enable   = 1'b1;
      cmrg_stop_lvl = '0;
      cmrg_mode     = 1'b0;
      flush         = 1'b1;
      idle_inputs();

      // Flush / reset state.
      @(negedge clk);
      #1;
      check("rdy0_in_flush", 32'(cmrg_coord_in_0_ready), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("rst_out0_valid", 32'(cmrg_coord_out_0_valid), 32'd0);
      check("rst_out1_valid", 32'(cmrg_coord_out_1_valid), 32'd0);
      check("rst_out0_data", 32'(cmrg_coord_out_0), 32'd0);
      check("rst_out1_data", 32'(cmrg_coord_out_1), 32'd0);
      check("rst_rdy0_idle", 32'(cmrg_coord_in_0_ready), 32'd1);
      check("rst_rdy1_idle", 32'(cmrg_coord_in_1_ready), 32'd0);

      // Directed drop-mode cases.
      load_case1();
      run_stream("case1", 1'b0, 2000, 1'b1);

      src0 = '{17'd3, 17'd4, 17'h10000, 17'h10100};
      src1 = '{17'd9, 17'h10000, 17'd8, 17'h10001, 17'h10100};
      exp0 = '{17'd3, 17'd4, 17'h10000, 17'h10100};
      exp1 = '{17'd9, 17'h10000, 17'd8, 17'h10001, 17'h10100};
      run_stream("case2", 1'b0, 2000, 1'b1);

      src0 = '{17'd1, 17'd2, 17'h10000, 17'h10100};
      src1 = '{17'h10000, 17'h10001, 17'h10100};
      exp0 = '{17'h10000, 17'h10100};
      exp1 = '{17'h10001, 17'h10100};
      run_stream("case3", 1'b0, 2000, 1'b1);

      load_case1();
      run_stream("case1_thr", 1'b1, 2000, 1'b1);

      // Flush mid-stream, then restart the first case.
      load_case1();
      run_stream("partial", 1'b0, 3, 1'b0);
      @(negedge clk);
      flush = 1'b1;
      cmrg_coord_in_0_valid = 1'b1;
      cmrg_coord_in_0       = 17'd5;
      #1;
      check("flush_rdy0", 32'(cmrg_coord_in_0_ready), 32'd0);
      check("flush_rdy1", 32'(cmrg_coord_in_1_ready), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      idle_inputs();
      #1;
      check("post_flush_v0", 32'(cmrg_coord_out_0_valid), 32'd0);
      check("post_flush_v1", 32'(cmrg_coord_out_1_valid), 32'd0);
      load_case1();
      run_stream("restart", 1'b1, 2000, 1'b1);

      // Bypass mode: outputs equal inputs.
      cmrg_mode = 1'b1;
      load_case1();
      exp0 = src0;
      exp1 = src1;
      run_stream("bypass", 1'b1, 2000, 1'b1);
      cmrg_mode = 1'b0;

      // tile_en / clk_en gating with a token parked in the outer FIFO.
      @(negedge clk);
      cmrg_coord_in_0       = 17'h10000;
      cmrg_coord_in_0_valid = 1'b1;
      @(negedge clk);
      tile_en               = 1'b0;
      cmrg_coord_in_1       = 17'd3;
      cmrg_coord_in_1_valid = 1'b1;
      cmrg_coord_out_0_ready = 1'b1;
      cmrg_coord_out_1_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("tile_off_rdy0", 32'(cmrg_coord_in_0_ready), 32'd0);
         check("tile_off_rdy1", 32'(cmrg_coord_in_1_ready), 32'd0);
         check("tile_off_v0", 32'(cmrg_coord_out_0_valid), 32'd0);
         check("tile_off_v1", 32'(cmrg_coord_out_1_valid), 32'd0);
         @(negedge clk);
      end
      idle_inputs();
      tile_en = 1'b1;
      #1;
      check("tile_on_v0", 32'(cmrg_coord_out_0_valid), 32'd1);
      check("tile_on_d0", 32'(cmrg_coord_out_0), 32'h10000);
      @(negedge clk);
      clk_en = 1'b0;
      cmrg_coord_in_0_valid  = 1'b1;
      cmrg_coord_out_0_ready = 1'b1;
      #1;
      check("clk_off_rdy0", 32'(cmrg_coord_in_0_ready), 32'd0);
      @(negedge clk);
      #1;
      check("clk_off_hold_v0", 32'(cmrg_coord_out_0_valid), 32'd1);
      check("clk_off_hold_d0", 32'(cmrg_coord_out_0), 32'h10000);
      cmrg_coord_in_0_valid = 1'b0;
      clk_en = 1'b1;
      @(negedge clk);
      #1;
      check("clk_on_pop_v0", 32'(cmrg_coord_out_0_valid), 32'd0);
      idle_inputs();

      // Randomized streams against the reference model.
      for (int r = 0; r < 12; r++) begin
         gen_random();
         model();
         run_stream($sformatf("rand%0d", r), 1'b1, 3000, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
